pulse_deliver_pacer: RTL and testbench



---
 rtl/pulse_deliver_pacer_pkg.sv | 22 ++
 rtl/pulse_deliver_pacer_1bit.sv | 96 +++++++++
 rtl/pulse_deliver_pacer.sv | 57 +++++
 tb/tb_pulse_deliver_pacer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pulse_deliver_pacer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pulse_deliver_pacer_pkg                                         |
// | Purpose  : Shared constants and helpers for the pulse pacer slice.         |
// |            Holds the legal parameter minimums and the holdoff counter      |
// |            width helper used by the per-channel pacer.                     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package pulse_deliver_pacer_pkg;

  // Smallest spacing that still guarantees pulse_out is never high on two
  // consecutive cycles.
  localparam int C_GAP_MIN   = 2;
  localparam int C_CNT_W_MIN = 1;

  // The holdoff counter must hold GAP-1; $clog2(GAP) bits suffice for that.
  function automatic int hold_width(input int gap);
    return (gap < 2) ? 1 : $clog2(gap);
  endfunction

endpackage : pulse_deliver_pacer_pkg
`default_nettype wire

// File: rtl/pulse_deliver_pacer_1bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pulse_pacer_1bit                                                |
// | Purpose  : One channel of the pacer. Counts pending events and releases   |
// |            them as single-cycle pulses spaced at least GAP cycles apart.  |
// |            Saturation of the backlog raises a sticky overflow flag.       |
// | Ports    : clk, rst_n     - clock, async active-low reset               |
// |            scan_enable    - suppresses launches while high              |
// |            event_in       - one event per high cycle                    |
// |            ovf_clr        - clears the overflow flag (set wins)         |
// |            pulse_out      - registered single-cycle launch pulse        |
// |            pending        - backlog count nonzero                       |
// |            overflow       - sticky overflow flag                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pulse_pacer_1bit
  import pulse_deliver_pacer_pkg::*;
#(
  parameter int GAP   = 9,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scan_enable,
  input  logic event_in,
  input  logic ovf_clr,
  output logic pulse_out,
  output logic pending,
  output logic overflow
);

  localparam int                HOLD_W      = hold_width(GAP);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(GAP - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE    = HOLD_W'(1);

  logic [CNT_W-1:0]  cnt,  cnt_next;
  logic [HOLD_W-1:0] hold, hold_next;
  logic              ovf,  ovf_next;
  logic              launch;
  logic              ovf_set;

  always_comb begin
    cnt_next  = cnt;
    hold_next = hold;
    ovf_set   = 1'b0;

    // A fresh event on an idle channel launches directly without touching cnt.
    launch = ((cnt != '0) || event_in) && (hold == '0) && !scan_enable;

    if (launch) begin
      hold_next = HOLD_RELOAD;
    end else if (hold != '0) begin
      hold_next = hold - HOLD_ONE;
    end

    if (event_in && !launch) begin
      if (cnt == CNT_MAX) begin
        ovf_set = 1'b1;               // backlog full: event dropped
      end else begin
        cnt_next = cnt + CNT_ONE;
      end
    end else if (!event_in && launch) begin
      cnt_next = cnt - CNT_ONE;
    end

    // A coincident clear loses to a new overflow.
    if (ovf_set) begin
      ovf_next = 1'b1;
    end else if (ovf_clr) begin
      ovf_next = 1'b0;
    end else begin
      ovf_next = ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      hold      <= '0;
      ovf       <= 1'b0;
      pulse_out <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      hold      <= hold_next;
      ovf       <= ovf_next;
      pulse_out <= launch;
    end
  end

  assign pending  = (cnt != '0);
  assign overflow = ovf;

endmodule : pulse_pacer_1bit
`default_nettype wire

// File: rtl/pulse_deliver_pacer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pulse_deliver_pacer                                             |
// | Purpose  : Source-domain scheduler in front of the pulse_deliver          |
// |            synchronizer. One independent pacer per event channel.         |
// | Ports    : clk, rst_n            - clock, async active-low reset        |
// |            scan_enable           - test mode, suppresses launches       |
// |            event_in[WIDTH]       - event strobes                        |
// |            ovf_clr[WIDTH]        - per-channel overflow clear           |
// |            pulse_out[WIDTH]      - paced pulses to synchronizer         |
// |            pending[WIDTH]        - backlog nonzero                      |
// |            overflow[WIDTH]       - sticky overflow                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pulse_deliver_pacer
  import pulse_deliver_pacer_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int GAP   = 9,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scan_enable,
  input  logic [WIDTH-1:0] event_in,
  input  logic [WIDTH-1:0] ovf_clr,
  output logic [WIDTH-1:0] pulse_out,
  output logic [WIDTH-1:0] pending,
  output logic [WIDTH-1:0] overflow
);

  if (GAP < C_GAP_MIN) begin : g_bad_gap
    $error("pulse_deliver_pacer: GAP must be >= 2");
  end

  if (CNT_W < C_CNT_W_MIN) begin : g_bad_cnt_w
    $error("pulse_deliver_pacer: CNT_W must be >= 1");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    pulse_pacer_1bit #(
      .GAP   (GAP),
      .CNT_W (CNT_W)
    ) u_pacer (
      .clk         (clk),
      .rst_n       (rst_n),
      .scan_enable (scan_enable),
      .event_in    (event_in[i]),
      .ovf_clr     (ovf_clr[i]),
      .pulse_out   (pulse_out[i]),
      .pending     (pending[i]),
      .overflow    (overflow[i])
    );
  end

endmodule : pulse_deliver_pacer
`default_nettype wire

// File: tb/tb_pulse_deliver_pacer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pulse_deliver_pacer                                          |
// | Purpose  : Self-checking bench. DUT A: WIDTH=2, GAP=9, CNT_W=4.           |
// |            DUT B: WIDTH=1, GAP=9, CNT_W=2 for saturation behaviour.       |
// |            Expected pulse edges are queued by the stimulus; a monitor     |
// |            pops and compares whenever a pulse appears.                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pulse_deliver_pacer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scan_enable;
  logic [1:0] ev_a, clr_a, pulse_a, pend_a, ovf_a;
  logic [0:0] ev_b, clr_b, pulse_b, pend_b, ovf_b;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  int exp0[$];
  int exp1[$];
  int expb[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  pulse_deliver_pacer #(.WIDTH(2), .GAP(9), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .scan_enable(scan_enable), .event_in(ev_a),
    .ovf_clr(clr_a), .pulse_out(pulse_a), .pending(pend_a), .overflow(ovf_a)
  );

  pulse_deliver_pacer #(.WIDTH(1), .GAP(9), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .scan_enable(scan_enable), .event_in(ev_b),
    .ovf_clr(clr_b), .pulse_out(pulse_b), .pending(pend_b), .overflow(ovf_b)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every observed pulse must match the next queued edge number.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pulse_a[0]) begin
        if (exp0.size() == 0) check("ch0 unexpected pulse", edge_n, -1);
        else check("ch0 pulse edge", edge_n, exp0.pop_front());
      end
      if (pulse_a[1]) begin
        if (exp1.size() == 0) check("ch1 unexpected pulse", edge_n, -1);
        else check("ch1 pulse edge", edge_n, exp1.pop_front());
      end
      if (pulse_b[0]) begin
        if (expb.size() == 0) check("b unexpected pulse", edge_n, -1);
        else check("b pulse edge", edge_n, expb.pop_front());
      end
    end
  end

  initial begin
    int e;
    rst_n = 1'b0; scan_enable = 1'b0;
    ev_a = '0; clr_a = '0; ev_b = '0; clr_b = '0;
    step(3);
    check("reset pulse_a", int'(pulse_a), 0);
    check("reset pend_a", int'(pend_a), 0);
    check("reset ovf_a", int'(ovf_a), 0);
    check("reset pulse_b", int'(pulse_b), 0);
    rst_n = 1'b1;
    step(2);

    // Single event on idle channel.
    e = edge_n;
    exp0.push_back(e + 1);
    ev_a = 2'b01; step(1); ev_a = 2'b00;
    check("single pending", int'(pend_a), 0);
    check("single overflow", int'(ovf_a), 0);
    step(12);

    // Burst of 4 on ch0.
    e = edge_n;
    exp0.push_back(e + 1); exp0.push_back(e + 10);
    exp0.push_back(e + 19); exp0.push_back(e + 28);
    ev_a = 2'b01; step(4); ev_a = 2'b00;
    check("burst pending after events", int'(pend_a), 1);
    step(15);
    check("burst pending before last", int'(pend_a), 1);
    step(9);
    check("burst pending drained", int'(pend_a), 0);
    step(12);

    // Independence: 3 on ch0, 1 on ch1.
    e = edge_n;
    exp0.push_back(e + 1); exp0.push_back(e + 10); exp0.push_back(e + 19);
    exp1.push_back(e + 1);
    ev_a = 2'b11; step(1); ev_a = 2'b01; step(2); ev_a = 2'b00;
    check("indep pending", int'(pend_a), 1);
    step(30);

    // scan_enable holds a backlog of 2.
    e = edge_n;
    scan_enable = 1'b1;
    ev_a = 2'b01; step(2); ev_a = 2'b00;
    check("scan pending", int'(pend_a), 1);
    check("scan no pulse", int'(pulse_a), 0);
    step(18);
    check("scan pending held", int'(pend_a), 1);
    exp0.push_back(e + 21); exp0.push_back(e + 30);
    scan_enable = 1'b0;
    step(25);
    check("scan drained", int'(pend_a), 0);

    // Saturation on CNT_W=2: 6 events -> 4 pulses, overflow set.
    e = edge_n;
    expb.push_back(e + 1); expb.push_back(e + 10);
    expb.push_back(e + 19); expb.push_back(e + 28);
    ev_b = 1'b1; step(6); ev_b = 1'b0;
    check("sat overflow set", int'(ovf_b), 1);
    check("sat pending", int'(pend_b), 1);
    step(34);
    check("sat overflow sticky", int'(ovf_b), 1);
    check("sat drained", int'(pend_b), 0);
    clr_b = 1'b1; step(1); clr_b = 1'b0;
    check("sat overflow cleared", int'(ovf_b), 0);

    // Set wins over coincident clear.
    e = edge_n;
    expb.push_back(e + 1); expb.push_back(e + 10);
    expb.push_back(e + 19); expb.push_back(e + 28);
    ev_b = 1'b1; step(4);
    check("setwin pre overflow", int'(ovf_b), 0);
    clr_b = 1'b1; step(1); ev_b = 1'b0; clr_b = 1'b0;
    check("setwin overflow", int'(ovf_b), 1);
    step(30);
    clr_b = 1'b1; step(1); clr_b = 1'b0;
    check("setwin cleared", int'(ovf_b), 0);
    step(3);

    // Reset mid-hold with cnt = 3.
    e = edge_n;
    exp0.push_back(e + 1);
    ev_a = 2'b01; step(4); ev_a = 2'b00;
    step(1);
    check("rst pre pending", int'(pend_a), 1);
    #2; rst_n = 1'b0; #1;
    check("rst pend_a", int'(pend_a), 0);
    check("rst pulse_a", int'(pulse_a), 0);
    check("rst ovf_a", int'(ovf_a), 0);
    step(2); rst_n = 1'b1;
    step(40);
    check("rst no backlog", int'(pend_a), 0);

    // Reset while a pulse is in flight drops it asynchronously.
    ev_a = 2'b01; step(1); ev_a = 2'b00;
    check("inflight pulse high", int'(pulse_a), 1);
    #3; rst_n = 1'b0; #1;
    check("inflight pulse dropped", int'(pulse_a), 0);
    step(2); rst_n = 1'b1;
    step(30);

    check("ch0 queue empty", exp0.size(), 0);
    check("ch1 queue empty", exp1.size(), 0);
    check("b queue empty", expb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_pulse_deliver_pacer
`default_nettype wire
